// File: rtl/sys_bus_bridge_if.sv
// CPU-side and peripheral-side signals of the system bus bridge.
// The master modport is the bridge's view; slave is the CPU/device side.
interface sys_bus_bridge_if;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWe;
    logic        PrRe;
    logic [31:0] PrRD;
    logic        PrReady;
    logic        PrErr;
    logic [1:0]  Dev_Addr;
    logic [31:0] Dev_WD;
    logic        T0_Wr;
    logic        T1_Wr;
    logic [31:0] T0_RD;
    logic [31:0] T1_RD;
    logic        T0_IRQ;
    logic        T1_IRQ;
    logic [5:0]  HWInt;

    modport master (
        input  PrAddr, PrWD, PrWe, PrRe, T0_RD, T1_RD, T0_IRQ, T1_IRQ,
        output PrRD, PrReady, PrErr, Dev_Addr, Dev_WD, T0_Wr, T1_Wr, HWInt
    );

    modport slave (
        output PrAddr, PrWD, PrWe, PrRe, T0_RD, T1_RD, T0_IRQ, T1_IRQ,
        input  PrRD, PrReady, PrErr, Dev_Addr, Dev_WD, T0_Wr, T1_Wr, HWInt
    );
endinterface

// File: rtl/sys_bus_bridge.sv
// CPU-to-peripheral bridge: address decode, timer register access with
// one-cycle write strobes, and sticky edge-detected interrupt pending bits.
module sys_bus_bridge #(
    parameter logic [31:0] BASE_T0 = 32'h0000_7F00,
    parameter logic [31:0] BASE_T1 = 32'h0000_7F10,
    parameter logic [31:0] BASE_BR = 32'h0000_7F20
) (
    input logic           clk,
    input logic           reset,
    sys_bus_bridge_if.master bus
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_T0, SEL_T1, SEL_BR} sel_t;

    state_t      state, state_nxt;
    sel_t        sel, sel_dec;
    logic        is_wr;
    logic        req;
    logic [1:0]  pend, mask, irq_prev;
    logic [1:0]  irq_now, irq_rise, pend_clr;
    logic        mask_wr;
    logic [31:0] rd_mux;

    always_comb begin
        req     = bus.PrWe | bus.PrRe;
        sel_dec = SEL_NONE;
        if (bus.PrAddr[1:0] == 2'b00 && bus.PrAddr[3:2] != 2'b11) begin
            if (bus.PrAddr[31:4] == BASE_T0[31:4])
                sel_dec = SEL_T0;
            else if (bus.PrAddr[31:4] == BASE_T1[31:4])
                sel_dec = SEL_T1;
            else if (bus.PrAddr[31:4] == BASE_BR[31:4] && !bus.PrAddr[3])
                sel_dec = SEL_BR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SETUP;
            SETUP:   state_nxt = is_wr ? STROBE : CAPTURE;
            STROBE:  state_nxt = DONE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.T0_Wr   = (state == STROBE) && (sel == SEL_T0);
        bus.T1_Wr   = (state == STROBE) && (sel == SEL_T1);
        bus.PrReady = (state == DONE);
        bus.PrErr   = (state == DONE) && (sel == SEL_NONE);
    end

    always_comb begin
        case (sel)
            SEL_T0:  rd_mux = bus.T0_RD;
            SEL_T1:  rd_mux = bus.T1_RD;
            SEL_BR:  rd_mux = bus.Dev_Addr[0] ? {30'b0, mask} : {30'b0, pend};
            default: rd_mux = '0;
        endcase
    end

    // Request fields are latched once on acceptance; later CPU changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Dev_Addr <= '0;
            bus.Dev_WD   <= '0;
            bus.PrRD     <= '0;
            sel          <= SEL_NONE;
            is_wr        <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                bus.Dev_Addr <= bus.PrAddr[3:2];
                bus.Dev_WD   <= bus.PrWD;
                sel          <= sel_dec;
                is_wr        <= bus.PrWe;
            end
            if (state == STROBE)
                bus.PrRD <= '0;
            else if (state == CAPTURE)
                bus.PrRD <= rd_mux;
        end
    end

    // Bridge-local writes land on the STROBE edge; a coincident rising edge keeps pend set.
    always_comb begin
        irq_now  = {bus.T1_IRQ, bus.T0_IRQ};
        irq_rise = irq_now & ~irq_prev;
        pend_clr = '0;
        mask_wr  = 1'b0;
        if (state == STROBE && sel == SEL_BR) begin
            if (bus.Dev_Addr[0])
                mask_wr = 1'b1;
            else
                pend_clr = bus.Dev_WD[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev  <= '0;
            pend      <= '0;
            mask      <= '0;
            bus.HWInt <= '0;
        end else begin
            irq_prev  <= irq_now;
            pend      <= (pend & ~pend_clr) | irq_rise;
            if (mask_wr)
                mask <= bus.Dev_WD[1:0];
            bus.HWInt <= {4'b0, pend & mask};
        end
    end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Directed and randomized checks of sys_bus_bridge against a transaction-level
// model of decode, latency, read data and interrupt pending/mask state.
module tb_sys_bus_bridge;

    localparam logic [31:0] BASE_T0 = 32'h0000_7F00;
    localparam logic [31:0] BASE_T1 = 32'h0000_7F10;
    localparam logic [31:0] BASE_BR = 32'h0000_7F20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sys_bus_bridge_if bus();

    sys_bus_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] t0_regs [4];
    logic [31:0] t1_regs [4];
    assign bus.T0_RD = t0_regs[bus.Dev_Addr];
    assign bus.T1_RD = t1_regs[bus.Dev_Addr];

    int   checks = 0;
    int   errors = 0;
    logic [1:0] pend_m, mask_m, prev_m;
    logic [5:0] hw_exp;
    bit   irq_rand;

    logic [31:0] addr_tab [14] = '{
        32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10, 32'h7F14, 32'h7F18,
        32'h7F1C, 32'h7F20, 32'h7F24, 32'h7F28, 32'h7F2C, 32'h8000, 32'h7F02
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: called at a negedge, advances the IRQ model over the rising edge.
    task automatic step(input logic [1:0] clr, input logic mwr, input logic [1:0] mval);
        if (irq_rand) {bus.T1_IRQ, bus.T0_IRQ} = 2'($urandom);
        @(posedge clk);
        hw_exp = {4'b0, pend_m & mask_m};
        pend_m = (pend_m & ~clr) | ({bus.T1_IRQ, bus.T0_IRQ} & ~prev_m);
        prev_m = {bus.T1_IRQ, bus.T0_IRQ};
        if (mwr) mask_m = mval;
        @(negedge clk);
        chk("hwint", 32'(bus.HWInt), 32'(hw_exp));
    endtask

    task automatic txn(input logic [31:0] addr, input logic [31:0] wd, input bit we, input bit re,
                       input bit force_irq, input logic [1:0] strobe_irq, input bit reassert);
        int          tgt;
        logic [1:0]  idx;
        logic [31:0] blk;
        logic [31:0] exp_rd;
        logic [1:0]  clr;
        bit          mwr;
        idx = addr[3:2];
        blk = addr & 32'hFFFF_FFF0;
        tgt = 0;
        if (addr[1:0] == 2'b00) begin
            if (blk == BASE_T0 && idx != 2'd3)      tgt = 1;
            else if (blk == BASE_T1 && idx != 2'd3) tgt = 2;
            else if (blk == BASE_BR && idx < 2'd2)  tgt = 3;
        end
        bus.PrAddr = addr; bus.PrWD = wd; bus.PrWe = we; bus.PrRe = re;
        step(2'b00, 1'b0, 2'b00);
        chk("setup_ready", 32'(bus.PrReady), 32'd0);
        chk("setup_t0wr", 32'(bus.T0_Wr), 32'd0);
        chk("setup_t1wr", 32'(bus.T1_Wr), 32'd0);
        if (reassert) begin
            bus.PrWe = 1'b1; bus.PrRe = 1'b0; bus.PrAddr = BASE_T0;
        end
        step(2'b00, 1'b0, 2'b00);
        chk("mid_t0wr", 32'(bus.T0_Wr), 32'(we && tgt == 1));
        chk("mid_t1wr", 32'(bus.T1_Wr), 32'(we && tgt == 2));
        chk("mid_ready", 32'(bus.PrReady), 32'd0);
        case (tgt)
            1:       exp_rd = t0_regs[idx];
            2:       exp_rd = t1_regs[idx];
            3:       exp_rd = (idx == 2'd0) ? {30'b0, pend_m} : {30'b0, mask_m};
            default: exp_rd = '0;
        endcase
        clr = (we && tgt == 3 && idx == 2'd0) ? wd[1:0] : 2'b00;
        mwr = we && tgt == 3 && idx == 2'd1;
        if (force_irq) {bus.T1_IRQ, bus.T0_IRQ} = strobe_irq;
        step(clr, mwr, wd[1:0]);
        chk("done_ready", 32'(bus.PrReady), 32'd1);
        chk("done_err", 32'(bus.PrErr), 32'(tgt == 0));
        chk("done_devaddr", 32'(bus.Dev_Addr), 32'(idx));
        chk("done_devwd", bus.Dev_WD, wd);
        chk("done_strobes", 32'({bus.T1_Wr, bus.T0_Wr}), 32'd0);
        if (!we || tgt == 0) chk("done_rd", bus.PrRD, exp_rd);
        bus.PrWe = 1'b0; bus.PrRe = 1'b0;
        step(2'b00, 1'b0, 2'b00);
        chk("after_ready", 32'(bus.PrReady), 32'd0);
        chk("after_err", 32'(bus.PrErr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            t0_regs[i] = $urandom;
            t1_regs[i] = $urandom;
        end
        irq_rand = 1'b0;
        pend_m = '0; mask_m = '0; prev_m = '0;
        reset = 1'b0;
        bus.PrAddr = '0; bus.PrWD = '0; bus.PrWe = 1'b0; bus.PrRe = 1'b0;
        bus.T0_IRQ = 1'b0; bus.T1_IRQ = 1'b0;
        #3;
        chk("rst_ready", 32'(bus.PrReady), 32'd0);
        chk("rst_err", 32'(bus.PrErr), 32'd0);
        chk("rst_rd", bus.PrRD, 32'd0);
        chk("rst_devaddr", 32'(bus.Dev_Addr), 32'd0);
        chk("rst_devwd", bus.Dev_WD, 32'd0);
        chk("rst_strobes", 32'({bus.T1_Wr, bus.T0_Wr}), 32'd0);
        chk("rst_hwint", 32'(bus.HWInt), 32'd0);
        #19 reset = 1'b1;
        @(negedge clk);

        txn(32'h7F00, 32'h9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        t1_regs[2] = 32'h1234;
        txn(32'h7F18, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        txn(32'h7F0C, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        txn(32'h8000, 32'h5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // Interrupt pending / mask behaviour
        txn(32'h7F24, 32'h3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        bus.T0_IRQ = 1'b1;
        step(2'b00, 1'b0, 2'b00);
        bus.T0_IRQ = 1'b0;
        step(2'b00, 1'b0, 2'b00);
        chk("hwint_pulse", 32'(bus.HWInt), 32'h1);
        txn(32'h7F20, 32'h1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("hwint_setwins", 32'(bus.HWInt), 32'h1);
        txn(32'h7F20, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        txn(32'h7F20, 32'h1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(2'b00, 1'b0, 2'b00);
        chk("hwint_cleared", 32'(bus.HWInt), 32'h0);
        txn(32'h7F20, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        bus.T0_IRQ = 1'b0;

        // Simultaneous write/read request, with a new request presented during SETUP
        txn(32'h7F14, 32'hABCD, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 2'b00);
            chk("single_ready", 32'(bus.PrReady), 32'd0);
            chk("single_t0wr", 32'(bus.T0_Wr), 32'd0);
        end

        // Asynchronous reset in STROBE
        bus.T1_IRQ = 1'b1;
        step(2'b00, 1'b0, 2'b00);
        bus.T1_IRQ = 1'b0;
        step(2'b00, 1'b0, 2'b00);
        chk("hwint_t1", 32'(bus.HWInt), 32'h2);
        bus.PrAddr = 32'h7F04; bus.PrWD = 32'h77; bus.PrWe = 1'b1;
        step(2'b00, 1'b0, 2'b00);
        step(2'b00, 1'b0, 2'b00);
        chk("strobe_before_rst", 32'(bus.T0_Wr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_t0wr", 32'(bus.T0_Wr), 32'd0);
        chk("arst_ready", 32'(bus.PrReady), 32'd0);
        chk("arst_hwint", 32'(bus.HWInt), 32'd0);
        bus.PrWe = 1'b0;
        pend_m = '0; mask_m = '0; prev_m = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0, 2'b00);
            chk("post_rst_ready", 32'(bus.PrReady), 32'd0);
            chk("post_rst_t0wr", 32'(bus.T0_Wr), 32'd0);
        end

        // Randomized traffic with random IRQ activity
        irq_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            bit w, r;
            a = addr_tab[$urandom_range(0, 13)];
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            txn(a, $urandom, w, r, 1'b0, 2'b00, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
